serial_add_sub: RTL
===================

// Module: serial_add_sub
// PURPOSE
//  Bit-serial WIDTH-bit adder/subtractor. One full-adder cell plus a carry flip-flop
//  processes one bit pair per clock, LSB first.
//  Successor to the single-bit combinational full adder: parametrised width, add/sub
//  mode, start/busy/done handshake, carry-out and signed-overflow flags.
//  Sits in the arithmetic datapath wherever area matters more than latency.
// PARAMETERS
//  WIDTH  8  operand/result width in bits; legal range WIDTH >= 2
// PORTS
//  clk       in   1      rising-edge clock
//  rst_n     in   1      asynchronous active-low reset
//  start     in   1      request; sampled only while busy==0
//  sub       in   1      0: a+b+cin; 1: a-b-cin (cin acts as borrow-in)
//  a         in   WIDTH  operand A; captured on the accepted start edge
//  b         in   WIDTH  operand B; captured on the accepted start edge
//  cin       in   1      carry-in / borrow-in; captured on the accepted start edge
//  sum       out  WIDTH  result register; changes only at completion
//  cout      out  1      final carry; in sub mode 1 = no borrow, 0 = borrow
//  overflow  out  1      signed overflow = carry into MSB XOR carry out of MSB
//  busy      out  1      high while an operation is in progress
//  done      out  1      single-cycle completion pulse
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, sum=0, cout=0, overflow=0, busy=0, done=0.
//   Shift registers, carry FF and bit counter are cleared.
//  FSM states: IDLE, RUN, DONE.
//  Start acceptance:
//   - start=1 with busy==0 (IDLE or DONE) at edge T0 is accepted.
//   - Load opA=a, opB = sub ? ~b : b, carry = cin ^ sub, count=0. Go to RUN.
//   - At T0: busy=1, done=0.
//  RUN, edges T1..T_WIDTH, bit i = count:
//   - s_i = opA[0]^opB[0]^carry.
//   - carry <= maj(opA[0], opB[0], carry).
//   - opA and opB shift right by 1.
//   - s_i shifts into the MSB of the internal result shift register.
//   - Before the last bit, record carry-into-MSB for the overflow flag.
//   - count increments.
//  Completion, edge T_WIDTH (count == WIDTH-1):
//   - sum <= completed result; cout <= final carry.
//   - overflow <= carry_into_MSB ^ final carry.
//   - busy <= 0, done <= 1. Go to DONE.
//  DONE: lasts one cycle. done drops at the next edge unless a new start is accepted.
//   A start accepted in the DONE cycle loads immediately (back-to-back operations).
//  Latency: done is high in the cycle after edge T_WIDTH, i.e. WIDTH cycles after the
//   accepted start edge. Throughput: one result per WIDTH cycles.
//  start while busy==1 is ignored. Operands may change freely while busy.
//  sum, cout and overflow hold their last values until the next completion.
//   An operation in progress never disturbs them.
//  All arithmetic is modulo 2^WIDTH; no saturation.
//  Reset mid-operation: the operation is discarded and all outputs return to reset values.
//  Counter width: $clog2(WIDTH) bits. Exactly WIDTH RUN edges occur, with no
//   off-by-one at WIDTH = 2^k.
// TESTING (WIDTH=8 unless noted)
//  1. add a=0F, b=01, cin=0 -> sum=10, cout=0, ovf=0; done exactly 8 cycles after start;
//     busy high for 8 cycles.
//  2. add a=FF, b=01, cin=0 -> sum=00, cout=1, ovf=0.
//     add a=7F, b=01 -> sum=80, cout=0, ovf=1.
//     add a=00, b=00, cin=1 -> sum=01.
//  3. sub a=05, b=07, cin=0 -> sum=FE, cout=0 (borrow), ovf=0.
//     sub a=80, b=01 -> sum=7F, cout=1, ovf=1.
//  4. start re-pulsed mid-op with new operands -> ignored, first result returned.
//     start held in the done cycle -> second op accepted; its done follows 8 cycles later.
//  5. rst_n low for 1 cycle at count=4 -> busy=0, done=0, sum=00.
//     A subsequent op completes correctly.
//  6. WIDTH=2 and WIDTH=16 random add/sub, 1000 vectors each vs {cout,sum} golden
//     model; check the ovf formula.

Source files
------------

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: one full-adder cell plus carry FF, LSB first.
// Latency: done pulses WIDTH cycles after the accepted start edge; one result per WIDTH cycles.
// Backpressure: start is accepted only while busy==0 (IDLE or DONE); start while busy is ignored.
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic             w_accept;
  logic             w_last;
  logic             w_s;
  logic             w_c;

  // The single full-adder cell working on the current LSB pair.
  assign w_s = r_opa[0] ^ r_opb[0] ^ r_carry;
  assign w_c = (r_opa[0] & r_opb[0]) | (r_opa[0] & r_carry) | (r_opb[0] & r_carry);

  assign busy     = (r_state == S_RUN);
  assign done     = (r_state == S_DONE);
  assign w_accept = start & ~busy;
  assign w_last   = (r_cnt == LAST);

  assign sum      = r_sum;
  assign cout     = r_cout;
  assign overflow = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: a start in the DONE cycle restarts immediately for back-to-back ops.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last)   w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand load, per-bit shift/accumulate, and result commit on the last bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      // Subtraction is a + ~b + 1; a borrow-in removes that +1, hence cin ^ sub.
      r_opa   <= a;
      r_opb   <= sub ? ~b : b;
      r_carry <= cin ^ sub;
      r_cnt   <= '0;
    end else if (r_state == S_RUN) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_c;
      r_res   <= {w_s, r_res[WIDTH-1:1]};
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        // On the MSB step r_carry is the carry into the MSB, w_c the carry out of it.
        r_sum  <= {w_s, r_res[WIDTH-1:1]};
        r_cout <= w_c;
        r_ovf  <= r_carry ^ w_c;
      end
    end
  end

endmodule
